// File: rtl/mod_147_11_hb_sched_if.sv
// Command/status bundle between the 10BASE-T1S link monitor / MAC side
// (master) and the heartbeat transmit scheduler (slave).
interface mod_147_11_hb_sched_if;
    logic       pcs_reset;
    logic       mr_autoneg_enable;
    logic       an_link_good;
    logic       multidrop;
    logic       tx_en;
    logic       hold_start;
    logic       tx_grant;
    logic [1:0] tx_cmd;
    logic       link_hold_timer_done;
    logic [1:0] sched_state;

    modport master (
        output pcs_reset,
        output mr_autoneg_enable,
        output an_link_good,
        output multidrop,
        output tx_en,
        output hold_start,
        input  tx_grant,
        input  tx_cmd,
        input  link_hold_timer_done,
        input  sched_state
    );

    modport slave (
        input  pcs_reset,
        input  mr_autoneg_enable,
        input  an_link_good,
        input  multidrop,
        input  tx_en,
        input  hold_start,
        output tx_grant,
        output tx_cmd,
        output link_hold_timer_done,
        output sched_state
    );
endinterface

// File: rtl/mod_147_11_hb_sched.sv
// Heartbeat/data transmit scheduler and link_hold_timer for the 10BASE-T1S
// point-to-point link monitor. MAC data (tx_en) and periodic HEARTBEAT
// insertion share the PCS transmit command path; the hold timer is an
// independent down-counter used by the link status state machine.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_OFF   | scheduler disabled, tx_cmd=NONE, no grant
// S_WAIT  | idle, counting cycles since last tx activity
// S_SEND  | HEARTBEAT being sent for HB_LEN cycles, MAC held off
// S_DATA  | MAC owns the transmit path (tx_grant=1)
module mod_147_11_hb_sched #(
    parameter logic [15:0] HB_PERIOD = 16'd1000,
    parameter logic [7:0]  HB_LEN    = 8'd4,
    parameter logic [15:0] HOLD_CYC  = 16'd4000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mod_147_11_hb_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_OFF  = 2'b00,
        S_WAIT = 2'b01,
        S_SEND = 2'b10,
        S_DATA = 2'b11
    } state_t;

    localparam logic [1:0]  CMD_HB    = 2'b10;
    localparam logic [1:0]  CMD_NONE  = 2'b11;
    localparam logic [15:0] IDLE_LAST = HB_PERIOD - 16'd1;
    localparam logic [7:0]  HB_LAST   = HB_LEN - 8'd1;
    localparam logic [15:0] HOLD_LOAD = HOLD_CYC - 16'd1;
    localparam logic [15:0] CNT16_MAX = 16'hFFFF;
    localparam logic [7:0]  CNT8_MAX  = 8'hFF;

    if (HB_PERIOD < 16'd2) begin : g_chk_hb_period
        $error("HB_PERIOD must be at least 2");
    end
    if (HB_LEN < 8'd1) begin : g_chk_hb_len
        $error("HB_LEN must be at least 1");
    end
    if (HOLD_CYC < 16'd2) begin : g_chk_hold_cyc
        $error("HOLD_CYC must be at least 2");
    end

    state_t      r_state;
    logic [15:0] r_idle_cnt;
    logic [7:0]  r_hb_cnt;
    logic [1:0]  r_tx_cmd;
    logic        r_tx_grant;
    logic [15:0] r_hold_cnt;
    logic        r_hold_done;
    logic        w_disable;

    // Outputs are registered alongside the state, so decode from the state
    // being entered rather than the current one.
    function automatic logic [1:0] f_cmd(state_t s);
        return (s == S_SEND) ? CMD_HB : CMD_NONE;
    endfunction

    function automatic logic f_grant(state_t s);
        return (s == S_DATA);
    endfunction

    assign w_disable = bus.pcs_reset | ~bus.mr_autoneg_enable |
                       ~bus.an_link_good | bus.multidrop;

    // Scheduler FSM with idle/heartbeat counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_OFF;
            r_idle_cnt <= 16'd0;
            r_hb_cnt   <= 8'd0;
            r_tx_cmd   <= CMD_NONE;
            r_tx_grant <= 1'b0;
        end else if (w_disable) begin
            // Any disable source drops whatever is in flight, including a frame.
            r_state    <= S_OFF;
            r_idle_cnt <= 16'd0;
            r_hb_cnt   <= 8'd0;
            r_tx_cmd   <= f_cmd(S_OFF);
            r_tx_grant <= f_grant(S_OFF);
        end else begin
            case (r_state)
                S_OFF: begin
                    r_state    <= S_WAIT;
                    r_idle_cnt <= 16'd0;
                    r_tx_cmd   <= f_cmd(S_WAIT);
                    r_tx_grant <= f_grant(S_WAIT);
                end
                S_WAIT: begin
                    if (bus.tx_en) begin
                        // MAC request beats a heartbeat due on the same cycle.
                        r_state    <= S_DATA;
                        r_idle_cnt <= 16'd0;
                        r_tx_cmd   <= f_cmd(S_DATA);
                        r_tx_grant <= f_grant(S_DATA);
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_state    <= S_SEND;
                        r_hb_cnt   <= 8'd0;
                        r_tx_cmd   <= f_cmd(S_SEND);
                        r_tx_grant <= f_grant(S_SEND);
                    end else begin
                        if (r_idle_cnt != CNT16_MAX) begin
                            r_idle_cnt <= r_idle_cnt + 16'd1;
                        end
                        r_tx_cmd   <= f_cmd(S_WAIT);
                        r_tx_grant <= f_grant(S_WAIT);
                    end
                end
                S_SEND: begin
                    if (r_hb_cnt == HB_LAST) begin
                        // Heartbeat always runs to completion; a pending
                        // MAC request is granted straight afterwards.
                        r_idle_cnt <= 16'd0;
                        if (bus.tx_en) begin
                            r_state    <= S_DATA;
                            r_tx_cmd   <= f_cmd(S_DATA);
                            r_tx_grant <= f_grant(S_DATA);
                        end else begin
                            r_state    <= S_WAIT;
                            r_tx_cmd   <= f_cmd(S_WAIT);
                            r_tx_grant <= f_grant(S_WAIT);
                        end
                    end else begin
                        if (r_hb_cnt != CNT8_MAX) begin
                            r_hb_cnt <= r_hb_cnt + 8'd1;
                        end
                        r_tx_cmd   <= f_cmd(S_SEND);
                        r_tx_grant <= f_grant(S_SEND);
                    end
                end
                S_DATA: begin
                    if (!bus.tx_en) begin
                        r_state    <= S_WAIT;
                        r_idle_cnt <= 16'd0;
                        r_tx_cmd   <= f_cmd(S_WAIT);
                        r_tx_grant <= f_grant(S_WAIT);
                    end else begin
                        r_tx_cmd   <= f_cmd(S_DATA);
                        r_tx_grant <= f_grant(S_DATA);
                    end
                end
                default: begin
                    r_state    <= S_OFF;
                    r_tx_cmd   <= CMD_NONE;
                    r_tx_grant <= 1'b0;
                end
            endcase
        end
    end

    // link_hold_timer: down-counter, restartable, only cleared by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt  <= 16'd0;
            r_hold_done <= 1'b1;
        end else if (bus.hold_start) begin
            // A start landing on the expiry cycle keeps done low.
            r_hold_cnt  <= HOLD_LOAD;
            r_hold_done <= 1'b0;
        end else if (r_hold_cnt != 16'd0) begin
            r_hold_cnt  <= r_hold_cnt - 16'd1;
        end else begin
            r_hold_done <= 1'b1;
        end
    end

    assign bus.tx_grant             = r_tx_grant;
    assign bus.tx_cmd               = r_tx_cmd;
    assign bus.link_hold_timer_done = r_hold_done;
    assign bus.sched_state          = r_state;

endmodule

// File: tb/tb_mod_147_11_hb_sched.sv
// Bench for the heartbeat scheduler: per-cycle expected outputs are queued
// as stimulus is applied and popped after each clock edge.
module tb_mod_147_11_hb_sched;

    localparam logic [15:0] P_HB_PERIOD = 16'd10;
    localparam logic [7:0]  P_HB_LEN    = 8'd4;
    localparam logic [15:0] P_HOLD_CYC  = 16'd8;

    localparam logic [1:0] C_HB   = 2'b10;
    localparam logic [1:0] C_NONE = 2'b11;
    localparam logic [1:0] ST_OFF  = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_SEND = 2'b10;
    localparam logic [1:0] ST_DATA = 2'b11;

    typedef struct packed {
        logic [1:0] cmd;
        logic       grant;
        logic [1:0] st;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    exp_t sb[$];
    logic sb_done[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mod_147_11_hb_sched_if u_if();

    mod_147_11_hb_sched #(
        .HB_PERIOD(P_HB_PERIOD),
        .HB_LEN   (P_HB_LEN),
        .HOLD_CYC (P_HOLD_CYC)
    ) u_dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (u_if.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t exp_of(logic [1:0] st);
        exp_t e;
        e.st    = st;
        e.cmd   = (st == ST_SEND) ? C_HB : C_NONE;
        e.grant = (st == ST_DATA);
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.cmd   = u_if.tx_cmd;
        o.grant = u_if.tx_grant;
        o.st    = u_if.sched_state;
        return o;
    endfunction

    task automatic test_reset();
        u_if.pcs_reset         = 1'b0;
        u_if.mr_autoneg_enable = 1'b1;
        u_if.an_link_good      = 1'b1;
        u_if.multidrop         = 1'b0;
        u_if.tx_en             = 1'b0;
        u_if.hold_start        = 1'b0;
        reset_n = 1'b0;
        #12;
        n_checks++;
        if (u_if.sched_state !== ST_OFF) begin
            n_fail++; $display("FAIL reset_state: got %b want %b", u_if.sched_state, ST_OFF);
        end
        n_checks++;
        if (u_if.tx_cmd !== C_NONE) begin
            n_fail++; $display("FAIL reset_cmd: got %b want %b", u_if.tx_cmd, C_NONE);
        end
        n_checks++;
        if (u_if.tx_grant !== 1'b0) begin
            n_fail++; $display("FAIL reset_grant: got %b want 0", u_if.tx_grant);
        end
        n_checks++;
        if (u_if.link_hold_timer_done !== 1'b1) begin
            n_fail++; $display("FAIL reset_done: got %b want 1", u_if.link_hold_timer_done);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (u_if.sched_state !== ST_OFF) begin
            n_fail++; $display("FAIL release_state: got %b want %b", u_if.sched_state, ST_OFF);
        end
    endtask

    // Pure idle from reset release: 10 NONE then 4 HEARTBEAT, repeating.
    task automatic test_idle_hb();
        exp_t ex, got;
        int   hb_seen = 0;
        for (int k = 1; k <= 42; k++) begin
            sb.push_back(exp_of((((k - 1) % 14) < 10) ? ST_WAIT : ST_SEND));
            @(posedge clk); #1;
            got = observed();
            ex  = sb.pop_front();
            if (got.cmd == C_HB) hb_seen++;
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL idle_hb cyc %0d: got cmd=%b grant=%b st=%b, want cmd=%b grant=%b st=%b",
                         k, got.cmd, got.grant, got.st, ex.cmd, ex.grant, ex.st);
            end
        end
        n_checks++;
        if (hb_seen !== 12) begin
            n_fail++; $display("FAIL idle_hb_count: got %0d want 12", hb_seen);
        end
    endtask

    // Frame requested at idle_cnt=5 for 20 cycles; heartbeat spacing restarts after it.
    task automatic test_data_preempt();
        exp_t ex, got;
        logic [1:0] st;
        int   grants = 0;
        for (int k = 0; k < 40; k++) begin
            u_if.tx_en = (k >= 6) && (k < 26);
            st = (k < 6) ? ST_WAIT : (k < 26) ? ST_DATA : (k < 36) ? ST_WAIT : ST_SEND;
            sb.push_back(exp_of(st));
            @(posedge clk); #1;
            got = observed();
            ex  = sb.pop_front();
            if (got.grant === 1'b1) grants++;
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL data_preempt cyc %0d: got cmd=%b grant=%b st=%b, want cmd=%b grant=%b st=%b",
                         k, got.cmd, got.grant, got.st, ex.cmd, ex.grant, ex.st);
            end
        end
        n_checks++;
        if (grants !== 20) begin
            n_fail++; $display("FAIL data_grant_len: got %0d want 20", grants);
        end
    endtask

    // tx_en rises during the second HEARTBEAT cycle: heartbeat still runs 4 cycles.
    task automatic test_hb_no_truncate();
        exp_t ex, got;
        logic [1:0] st;
        for (int k = 0; k < 17; k++) begin
            u_if.tx_en = (k >= 12);
            st = (k < 10) ? ST_WAIT : (k < 14) ? ST_SEND : ST_DATA;
            sb.push_back(exp_of(st));
            @(posedge clk); #1;
            got = observed();
            ex  = sb.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++;
                $display("FAIL hb_no_truncate cyc %0d: got cmd=%b grant=%b st=%b, want cmd=%b grant=%b st=%b",
                         k, got.cmd, got.grant, got.st, ex.cmd, ex.grant, ex.st);
            end
        end
    endtask

    // Each disable source mid-DATA: OFF next edge, WAIT one edge after release, then DATA.
    task automatic test_disable();
        exp_t ex, got;
        logic [1:0] st;
        for (int src = 3; src >= 0; src--) begin
            for (int ph = 0; ph < 4; ph++) begin
                u_if.tx_en             = 1'b1;
                u_if.pcs_reset         = (src == 0) && (ph < 2);
                u_if.mr_autoneg_enable = !((src == 1) && (ph < 2));
                u_if.an_link_good      = !((src == 2) && (ph < 2));
                u_if.multidrop         = (src == 3) && (ph < 2);
                st = (ph < 2) ? ST_OFF : (ph == 2) ? ST_WAIT : ST_DATA;
                sb.push_back(exp_of(st));
                @(posedge clk); #1;
                got = observed();
                ex  = sb.pop_front();
                n_checks++;
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL disable src %0d ph %0d: got cmd=%b grant=%b st=%b, want cmd=%b grant=%b st=%b",
                             src, ph, got.cmd, got.grant, got.st, ex.cmd, ex.grant, ex.st);
                end
            end
        end
        u_if.tx_en = 1'b0;
        sb.push_back(exp_of(ST_WAIT));
        @(posedge clk); #1;
        got = observed();
        ex  = sb.pop_front();
        n_checks++;
        if (got !== ex) begin
            n_fail++;
            $display("FAIL disable_exit: got cmd=%b grant=%b st=%b, want cmd=%b grant=%b st=%b",
                     got.cmd, got.grant, got.st, ex.cmd, ex.grant, ex.st);
        end
    endtask

    // Hold timer with restarts at 0, 5 and on the expiry cycle (13); runs with pcs_reset high.
    task automatic test_hold_timer();
        logic ex, got;
        int   last = -100;
        u_if.pcs_reset = 1'b1;
        n_checks++;
        if (u_if.link_hold_timer_done !== 1'b1) begin
            n_fail++; $display("FAIL hold_idle: got %b want 1", u_if.link_hold_timer_done);
        end
        for (int k = 0; k < 26; k++) begin
            u_if.hold_start = (k == 0) || (k == 5) || (k == 13);
            if (u_if.hold_start) last = k;
            sb_done.push_back((k - last) >= int'(P_HOLD_CYC));
            @(posedge clk); #1;
            got = u_if.link_hold_timer_done;
            ex  = sb_done.pop_front();
            n_checks++;
            if (got !== ex) begin
                n_fail++; $display("FAIL hold_timer cyc %0d: got done=%b want %b", k, got, ex);
            end
        end
        u_if.hold_start = 1'b0;
        u_if.pcs_reset  = 1'b0;
    endtask

    // Asynchronous reset in the middle of a HEARTBEAT with the hold timer running.
    task automatic test_async_reset();
        bit found = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            u_if.hold_start = 1'b1;
            @(posedge clk); #1;
            if (u_if.tx_cmd === C_HB) found = 1;
        end
        u_if.hold_start = 1'b0;
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL async_wait_hb: got no HEARTBEAT within 40 cycles, want one");
        end else begin
            #2;
            n_checks++;
            if (u_if.link_hold_timer_done !== 1'b0) begin
                n_fail++; $display("FAIL async_pre_done: got %b want 0", u_if.link_hold_timer_done);
            end
            reset_n = 1'b0;
            #1;
            n_checks++;
            if (u_if.sched_state !== ST_OFF) begin
                n_fail++; $display("FAIL async_state: got %b want %b", u_if.sched_state, ST_OFF);
            end
            n_checks++;
            if (u_if.tx_cmd !== C_NONE) begin
                n_fail++; $display("FAIL async_cmd: got %b want %b", u_if.tx_cmd, C_NONE);
            end
            n_checks++;
            if (u_if.tx_grant !== 1'b0) begin
                n_fail++; $display("FAIL async_grant: got %b want 0", u_if.tx_grant);
            end
            n_checks++;
            if (u_if.link_hold_timer_done !== 1'b1) begin
                n_fail++; $display("FAIL async_done: got %b want 1", u_if.link_hold_timer_done);
            end
            @(posedge clk); #1;
            n_checks++;
            if (u_if.sched_state !== ST_OFF) begin
                n_fail++; $display("FAIL async_held: got %b want %b", u_if.sched_state, ST_OFF);
            end
            reset_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_idle_hb();
        test_data_preempt();
        test_hb_no_truncate();
        test_disable();
        test_hold_timer();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, want finished");
        $fatal(1, "watchdog expired");
    end

endmodule
